// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared encodings and defaults for the write-back selection stage.
//   reg_dst_e    : destination register select (rt / rd / link / none)
//   wb_src_e     : write data source select (alu / mem / pc link / upper imm)
//   mem_size_e   : load access size used by sub-word alignment
//   LINK_REG_DEF : default link destination register
//   PC_INC_DEF   : default offset added to pc for link data
// -----------------------------------------------------------------------------
package wb_pkg;

   typedef enum logic [1:0] {
      RD_RT   = 2'b00,
      RD_RD   = 2'b01,
      RD_LINK = 2'b10,
      RD_NONE = 2'b11
   } reg_dst_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_MEM  = 2'b01,
      WB_LINK = 2'b10,
      WB_LUI  = 2'b11
   } wb_src_e;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10
   } mem_size_e;

   localparam int unsigned LINK_REG_DEF = 31;
   localparam int unsigned PC_INC_DEF   = 4;

endpackage

// File: rtl/wb_load_align.sv
// -----------------------------------------------------------------------------
// wb_load_align
// Combinational sub-word load extraction and sign/zero extension.
// Only built when WB_SUBWORD_LOAD_EN is defined, since it is instantiated
// by wb_select_stage only in that build.
// Ports:
//   mem_data     in  DATA_W  raw word returned by memory
//   mem_size     in  2       SZ_WORD / SZ_HALF / SZ_BYTE
//   mem_unsigned in  1       zero-extend sub-word result when set
//   addr_lo      in  2       load address bits [1:0]
//   load_data    out DATA_W  aligned, extended load result
// -----------------------------------------------------------------------------
`ifdef WB_SUBWORD_LOAD_EN
module wb_load_align
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] mem_data,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [1:0]        addr_lo,
   output logic [DATA_W-1:0] load_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        ext;

   always_comb begin
      byte_v    = mem_data[{addr_lo, 3'b000} +: 8];
      half_v    = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
      ext       = 1'b0;
      load_data = mem_data;
      case (mem_size_e'(mem_size))
         SZ_BYTE: begin
            ext       = byte_v[7] & ~mem_unsigned;
            load_data = {{(DATA_W-8){ext}}, byte_v};
         end
         SZ_HALF: begin
            ext       = half_v[15] & ~mem_unsigned;
            load_data = {{(DATA_W-16){ext}}, half_v};
         end
         // Word and the unused 2'b11 encoding pass the word through.
         default: load_data = mem_data;
      endcase
   end

endmodule
`endif

// File: rtl/wb_select_stage.sv
// -----------------------------------------------------------------------------
// wb_select_stage
// Registered write-back selection stage: picks destination register and write
// data from MEM-stage results, holds them in a stallable/flushable register,
// drives the register file write port and counts accepted instructions.
// Optional feature macro: WB_SUBWORD_LOAD_EN (sub-word load alignment on the
// memory source; when undefined mem_size/mem_unsigned/addr_lo are ignored).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   stall, flush          hold stage / discard incoming (flush wins)
//   in_valid, reg_write   incoming instruction valid / writes a register
//   reg_dst, data_to_reg  destination and data source selects
//   instr_rt, instr_rd    candidate destination fields
//   alu_data, mem_data,
//   pc, imm16             candidate data sources
//   mem_size, mem_unsigned,
//   addr_lo               sub-word load controls
//   wb_valid, wb_we,
//   wb_addr, wb_data      registered write-back outputs
//   retire_cnt            accepted-instruction counter (wraps)
// -----------------------------------------------------------------------------
module wb_select_stage
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LINK_REG = LINK_REG_DEF,
   parameter int unsigned PC_INC   = PC_INC_DEF,
   parameter int unsigned CNT_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              reg_write,
   input  logic [1:0]        reg_dst,
   input  logic [1:0]        data_to_reg,
   input  logic [REG_AW-1:0] instr_rt,
   input  logic [REG_AW-1:0] instr_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] pc,
   input  logic [15:0]       imm16,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [1:0]        addr_lo,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic [DATA_W-1:0] mem_sel;
   logic [DATA_W-1:0] lui_data;
   logic [REG_AW-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   logic              valid_q,     valid_d;
   logic              reg_write_q, reg_write_d;
   logic              no_dst_q,    no_dst_d;
   logic [REG_AW-1:0] addr_q,      addr_d;
   logic [DATA_W-1:0] data_q,      data_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;

`ifdef WB_SUBWORD_LOAD_EN
   wb_load_align #(
      .DATA_W (DATA_W)
   ) u_load_align (
      .mem_data     (mem_data),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .addr_lo      (addr_lo),
      .load_data    (mem_sel)
   );
`else
   logic unused_subword_ctl;
   assign unused_subword_ctl = ^{mem_size, mem_unsigned, addr_lo};
   assign mem_sel = mem_data;
`endif

   // Destination and data selection
   always_comb begin
      lui_data        = '0;
      lui_data[31:16] = imm16;

      sel_addr = '0;
      case (reg_dst_e'(reg_dst))
         RD_RT:   sel_addr = instr_rt;
         RD_RD:   sel_addr = instr_rd;
         RD_LINK: sel_addr = REG_AW'(LINK_REG);
         default: sel_addr = '0;
      endcase

      sel_data = alu_data;
      case (wb_src_e'(data_to_reg))
         WB_ALU:  sel_data = alu_data;
         WB_MEM:  sel_data = mem_sel;
         WB_LINK: sel_data = pc + DATA_W'(PC_INC);
         default: sel_data = lui_data;
      endcase
   end

   // Stage register next state: flush clears valid only, stall holds all
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      no_dst_d    = no_dst_q;
      addr_d      = addr_q;
      data_d      = data_q;
      cnt_d       = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d     = in_valid;
         reg_write_d = reg_write;
         no_dst_d    = (reg_dst_e'(reg_dst) == RD_NONE);
         addr_d      = sel_addr;
         data_d      = sel_data;
         if (in_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         no_dst_q    <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         no_dst_q    <= no_dst_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
      end
   end

   assign wb_valid   = valid_q;
   assign wb_we      = valid_q && reg_write_q && !no_dst_q && (addr_q != '0);
   assign wb_addr    = addr_q;
   assign wb_data    = data_q;
   assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_select_stage
// Self-checking bench for wb_select_stage (retire counter reduced to 4 bits so
// the wrap is reachable). Directed cases with literal expectations followed by
// randomized traffic checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_wb_select_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          reg_write = 1'b0;
   logic [1:0]    reg_dst = 2'b00;
   logic [1:0]    data_to_reg = 2'b00;
   logic [AW-1:0] instr_rt = '0;
   logic [AW-1:0] instr_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic [DW-1:0] mem_data = '0;
   logic [DW-1:0] pc = '0;
   logic [15:0]   imm16 = '0;
   logic [1:0]    mem_size = 2'b00;
   logic          mem_unsigned = 1'b0;
   logic [1:0]    addr_lo = 2'b00;
   logic          wb_valid;
   logic          wb_we;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic [CW-1:0] retire_cnt;

   wb_select_stage #(
      .DATA_W   (DW),
      .REG_AW   (AW),
      .LINK_REG (31),
      .PC_INC   (4),
      .CNT_W    (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .in_valid     (in_valid),
      .reg_write    (reg_write),
      .reg_dst      (reg_dst),
      .data_to_reg  (data_to_reg),
      .instr_rt     (instr_rt),
      .instr_rd     (instr_rd),
      .alu_data     (alu_data),
      .mem_data     (mem_data),
      .pc           (pc),
      .imm16        (imm16),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .addr_lo      (addr_lo),
      .wb_valid     (wb_valid),
      .wb_we        (wb_we),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .retire_cnt   (retire_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   bit          chk_en   = 1'b0;

   // Model of what the stage must be presenting
   bit          m_valid      = 1'b0;
   bit          m_we         = 1'b0;
   bit          m_addr_known = 1'b0;
   int unsigned m_addr       = 0;
   logic [31:0] m_data       = '0;
   int unsigned m_cnt        = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input int unsigned sz,
                                              input bit uns, input int unsigned lo);
      int unsigned v;
      v = w;
`ifdef WB_SUBWORD_LOAD_EN
      if (sz == 2) begin
         v = (w >> (8 * lo)) & 32'hFF;
         if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      end else if (sz == 1) begin
         v = (lo >= 2) ? (w >> 16) : (w & 32'hFFFF);
         if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      end
`endif
      return v;
   endfunction

   // Advance the model by one clock edge using the inputs presented for it
   task automatic model_edge();
      int unsigned dest;
      if (flush) begin
         m_valid = 1'b0;
         m_we    = 1'b0;
      end else if (!stall) begin
         case (reg_dst)
            2'd0:    dest = instr_rt;
            2'd1:    dest = instr_rd;
            2'd2:    dest = 31;
            default: dest = 0;
         endcase
         m_addr_known = (reg_dst != 2'd3);
         m_addr  = dest;
         m_valid = in_valid;
         m_we    = in_valid && reg_write && (reg_dst != 2'd3) && (dest != 0);
         case (data_to_reg)
            2'd0:    m_data = alu_data;
            2'd1:    m_data = model_load(mem_data, mem_size, mem_unsigned, addr_lo);
            2'd2:    m_data = pc + 32'd4;
            default: m_data = {imm16, 16'h0000};
         endcase
         if (in_valid) m_cnt = (m_cnt + 1) % 16;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_in(input bit v, input bit rw, input logic [1:0] rdst, input logic [1:0] src,
                         input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pcv, input logic [15:0] imm);
      in_valid = v;   reg_write = rw;  reg_dst = rdst; data_to_reg = src;
      instr_rt = rt;  instr_rd = rd;   alu_data = alu; mem_data = mem;
      pc = pcv;       imm16 = imm;
   endtask

   task automatic rand_in();
      in_valid     = ($urandom_range(0, 3) != 0);
      reg_write    = ($urandom_range(0, 4) != 0);
      reg_dst      = 2'($urandom_range(0, 3));
      data_to_reg  = 2'($urandom_range(0, 3));
      instr_rt     = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      instr_rd     = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      alu_data     = $urandom;
      mem_data     = $urandom;
      pc           = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      imm16        = 16'($urandom);
      mem_size     = 2'($urandom_range(0, 2));
      mem_unsigned = 1'($urandom);
      addr_lo      = 2'($urandom);
   endtask

   // Called at a negedge: asynchronous reset must clear outputs immediately
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst_valid", wb_valid, 0);
      chk("rst_we", wb_we, 0);
      chk("rst_addr", wb_addr, 0);
      chk("rst_data", wb_data, 0);
      chk("rst_cnt", retire_cnt, 0);
      m_valid = 1'b0; m_we = 1'b0; m_addr_known = 1'b0;
      m_addr = 0; m_data = '0; m_cnt = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Compare process: every cycle outputs are meaningful
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         chk("wb_valid", wb_valid, m_valid);
         chk("wb_we", wb_we, m_we);
         chk("retire_cnt", retire_cnt, m_cnt);
         if (m_valid && m_addr_known) chk("wb_addr", wb_addr, m_addr);
         if (m_valid) chk("wb_data", wb_data, m_data);
      end
   end

   initial begin
      #1;
      chk("init_valid", wb_valid, 0);
      chk("init_we", wb_we, 0);
      chk("init_addr", wb_addr, 0);
      chk("init_data", wb_data, 0);
      chk("init_cnt", retire_cnt, 0);
      @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;

      // Basic rd write from ALU
      set_in(1, 1, 2'b01, 2'b00, 5'd3, 5'd9, 32'h1234, 32'h0, 32'h0, 16'h0);
      cycle();
      chk("t1_we", wb_we, 1);
      chk("t1_addr", wb_addr, 9);
      chk("t1_data", wb_data, 32'h1234);
      chk("t1_cnt", retire_cnt, 1);

      // Link write
      set_in(1, 1, 2'b10, 2'b10, 5'd3, 5'd9, 32'h0, 32'h0, 32'h00400010, 16'h0);
      cycle();
      chk("link_addr", wb_addr, 31);
      chk("link_data", wb_data, 32'h00400014);
      chk("link_cnt", retire_cnt, 2);

      // Write to $0 suppressed
      set_in(1, 1, 2'b00, 2'b00, 5'd0, 5'd9, 32'h55, 32'h0, 32'h0, 16'h0);
      cycle();
      chk("r0_valid", wb_valid, 1);
      chk("r0_we", wb_we, 0);

      // Upper immediate, then 3 stalled cycles with new valid inputs
      set_in(1, 1, 2'b01, 2'b11, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 16'hABCD);
      cycle();
      chk("lui_data", wb_data, 32'hABCD0000);
      chk("lui_we", wb_we, 1);
      chk("lui_cnt", retire_cnt, 4);
      for (int i = 0; i < 3; i++) begin
         rand_in();
         in_valid = 1'b1;
         stall    = 1'b1;
         cycle();
         chk("stall_data", wb_data, 32'hABCD0000);
         chk("stall_we", wb_we, 1);
         chk("stall_addr", wb_addr, 5);
         chk("stall_cnt", retire_cnt, 4);
      end

      // Flush beats stall
      flush = 1'b1;
      in_valid = 1'b1;
      cycle();
      chk("flush_valid", wb_valid, 0);
      chk("flush_we", wb_we, 0);
      chk("flush_cnt", retire_cnt, 4);

      // Reset mid-stall/mid-flush, then first capture after release
      do_reset();
      stall = 1'b0; flush = 1'b0;
      set_in(1, 1, 2'b01, 2'b00, 5'd0, 5'd12, 32'hCAFE0001, 32'h0, 32'h0, 16'h0);
      cycle();
      chk("post_rst_addr", wb_addr, 12);
      chk("post_rst_cnt", retire_cnt, 1);

      // Memory source
      mem_size = 2'b10; addr_lo = 2'd2; mem_unsigned = 1'b1;
      set_in(1, 1, 2'b01, 2'b01, 5'd0, 5'd7, 32'h0, 32'h80FF7F01, 32'h0, 16'h0);
      cycle();
`ifdef WB_SUBWORD_LOAD_EN
      chk("lbu_data", wb_data, 32'h000000FF);
      mem_unsigned = 1'b0;
      cycle();
      chk("lb_data", wb_data, 32'hFFFFFFFF);
      mem_size = 2'b01;
      cycle();
      chk("lh_data", wb_data, 32'hFFFF80FF);
`else
      chk("mem_pass", wb_data, 32'h80FF7F01);
`endif

      // Counter wrap with 4-bit counter
      do_reset();
      set_in(1, 0, 2'b11, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
      repeat (15) cycle();
      chk("cnt_max", retire_cnt, 15);
      cycle();
      chk("cnt_wrap", retire_cnt, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rand_in();
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            cycle();
         end
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
